// File: rtl/edge_detect_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Mode encoding per channel: 00 off, 01 rise, 10 fall, 11 both.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF,
    EDGE_RISE,
    EDGE_FALL,
    EDGE_BOTH
  } edge_mode_t;

  localparam int MIN_SYNC_STAGES = 2;

  // True when a transition to new_lvl is an event of interest for mode m.
  function automatic logic edge_hit(edge_mode_t m, logic new_lvl);
    logic hit;
    hit = 1'b0;
    unique case (m)
      EDGE_OFF:  hit = 1'b0;
      EDGE_RISE: hit = new_lvl;
      EDGE_FALL: hit = ~new_lvl;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: synchroniser, optional debounce, level/pulse/flag.
// Debounce counter present only when EDGE_DEBOUNCE_EN is defined.
module edge_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef EDGE_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       pulse,
  output logic       flag
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   chg;
  logic                   accept;
  edge_mode_t             m;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign chg    = sync_s ^ level;
  assign m      = edge_mode_t'(mode);

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

`ifdef EDGE_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign accept = chg && (cnt == LAST);

  // Count consecutive cycles the synced input disagrees with level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!chg || accept) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign accept = chg;
`endif

  // Accept a level change, emit the event pulse, keep the sticky flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      pulse <= 1'b0;
      flag  <= 1'b0;
    end else begin
      flag <= pulse | (flag & ~clr);
      if (accept) begin
        level <= sync_s;
        pulse <= edge_hit(m, sync_s);
      end else begin
        pulse <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_edge_detect.sv
// N_CH independent edge-detect channels plus an any-event summary.
// Define EDGE_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stability filter.
module multi_edge_detect
  import edge_detect_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   din,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   pulse,
  output logic [N_CH-1:0]   flag,
  output logic              any_evt
);

  if (N_CH < 1) begin : g_bad_nch
    $error("multi_edge_detect: N_CH must be >= 1");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("multi_edge_detect: SYNC_STAGES too small");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("multi_edge_detect: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef EDGE_DEBOUNCE_EN
      ,
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .din  (din[i]),
      .mode (mode[2*i+1:2*i]),
      .clr  (clr[i]),
      .level(level[i]),
      .pulse(pulse[i]),
      .flag (flag[i])
    );
  end

  assign any_evt = |flag;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect with a window-based reference model.
// Builds with or without EDGE_DEBOUNCE_EN.
module tb_multi_edge_detect;

  localparam int N = 4;
  localparam int S = 2;
`ifdef EDGE_DEBOUNCE_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif
  localparam int LAT = S + D;

  logic         clk;
  logic         reset;
  logic [N-1:0] din;
  logic [7:0]   mode;
  logic [N-1:0] clr;
  logic [N-1:0] level;
  logic [N-1:0] pulse;
  logic [N-1:0] flag;
  logic         any_evt;

  int vectors;
  int errors;

  multi_edge_detect #(
    .N_CH(N),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .mode   (mode),
    .clr    (clr),
    .level  (level),
    .pulse  (pulse),
    .flag   (flag),
    .any_evt(any_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: level follows a change once the last D synced samples
  // all disagree with it; synced sample seen at edge t is din sampled at t-S.
  logic [N-1:0] m_level;
  logic [N-1:0] m_pulse;
  logic [N-1:0] m_flag;
  bit           hist[N][$];

  always @(posedge clk or negedge reset) begin
    logic [N-1:0] nl, np, nf;
    if (!reset) begin
      m_level <= '0;
      m_pulse <= '0;
      m_flag  <= '0;
      for (int c = 0; c < N; c++) begin
        hist[c].delete();
        for (int k = 0; k < S + D; k++) hist[c].push_back(1'b0);
      end
    end else begin
      nl = m_level;
      np = '0;
      nf = m_flag;
      for (int c = 0; c < N; c++) begin
        bit acc;
        int sz;
        acc = 1'b1;
        sz  = hist[c].size();
        for (int j = 0; j < D; j++)
          if (hist[c][sz-S-j] == m_level[c]) acc = 1'b0;
        nf[c] = m_pulse[c] | (m_flag[c] & ~clr[c]);
        if (acc) begin
          nl[c] = ~m_level[c];
          np[c] = nl[c] ? mode[2*c] : mode[2*c+1];
        end
        hist[c].push_back(din[c]);
        if (hist[c].size() > 64) void'(hist[c].pop_front());
      end
      m_level <= nl;
      m_pulse <= np;
      m_flag  <= nf;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    vectors++;
    if ({level, pulse, flag, any_evt} !==
        {m_level, m_pulse, m_flag, |m_flag}) begin
      errors++;
      $display("FAIL model: lvl=%h pul=%h flg=%h any=%b req lvl=%h pul=%h flg=%h any=%b",
               level, pulse, flag, any_evt,
               m_level, m_pulse, m_flag, |m_flag);
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b0;
    din     = 4'hF;
    mode    = 8'h55;
    clr     = 4'h0;

    // 1: reset with inputs high, then release
    tick(3);
    chk("rst_level", level, 4'h0);
    chk("rst_pulse", pulse, 4'h0);
    chk("rst_flag", flag, 4'h0);
    chk("rst_any", {3'b0, any_evt}, 4'h0);
    reset = 1'b1;
    tick(LAT - 1);
    chk("rel_nopulse", pulse, 4'h0);
    tick(1);
    chk("rel_pulse", pulse, 4'hF);
    chk("rel_level", level, 4'hF);
    tick(1);
    chk("rel_pulse_end", pulse, 4'h0);
    chk("rel_flag", flag, 4'hF);
    chk("rel_any", {3'b0, any_evt}, 4'h1);
    clr = 4'hF;
    tick(1);
    clr = 4'h0;
    chk("clr_all", flag, 4'h0);

    // 2: rise-only on ch0
    mode = 8'h01;
    din  = 4'h0;
    tick(10);
    chk("fall_noflag", flag, 4'h0);
    din[0] = 1'b1;
    tick(LAT);
    chk("rise_pulse", pulse, 4'h1);
    tick(1);
    chk("rise_pulse_end", pulse, 4'h0);
    tick(9);
    din[0] = 1'b0;
    tick(10);
    chk("rise_flag", flag, 4'h1);
    chk("rise_level", level, 4'h0);

    // 3: both edges on ch1
    mode = 8'h0C;
    clr  = 4'hF;
    tick(1);
    clr  = 4'h0;
    for (int k = 0; k < 3; k++) begin
      din[1] = ~din[1];
      tick(LAT);
      chk("both_pulse", pulse, 4'h2);
      tick(1);
      chk("both_end", pulse, 4'h0);
      tick(4);
    end

    // 4: clear racing a set on ch2
    mode = 8'h10;
    clr  = 4'hF;
    tick(1);
    clr  = 4'h0;
    din[2] = 1'b1;
    tick(LAT);
    chk("race_pulse", pulse, 4'h4);
    clr = 4'h4;
    tick(1);
    chk("race_flag", flag, 4'h4);
    clr = 4'hF;
    tick(1);
    clr = 4'h0;
    chk("race_clr", flag, 4'h0);
    chk("race_any", {3'b0, any_evt}, 4'h0);

    // 5: short glitch and a stable high on ch3
    mode = 8'h40;
    din[3] = 1'b1;
    tick(2);
    din[3] = 1'b0;
    tick(10);
`ifdef EDGE_DEBOUNCE_EN
    chk("glitch_flag", flag, 4'h0);
    din[3] = 1'b1;
    tick(LAT - 1);
    chk("deb_nopulse", pulse, 4'h0);
    tick(1);
    chk("deb_pulse", pulse, 4'h8);
    tick(5);
    din[3] = 1'b0;
    tick(10);
`else
    chk("glitch_flag", flag, 4'h8);
`endif
    clr = 4'hF;
    tick(1);
    clr = 4'h0;

    // 6: async reset in the middle of a pending change
    din[3] = 1'b1;
    tick(LAT - 1);
    reset  = 1'b0;
    din[3] = 1'b0;
    #1;
    chk("arst_level", level, 4'h0);
    chk("arst_flag", flag, 4'h0);
    chk("arst_pulse", pulse, 4'h0);
    tick(2);
    reset = 1'b1;
    tick(12);
    chk("arst_noflag", flag, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
